// File: rtl/decade_pkg.sv
// decade_pkg: shared encodings and helpers for the cascaded BCD decade chain
package decade_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_e;
  function automatic logic [DIGIT_W-1:0] bcd_sanitise(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? '0 : d;
  endfunction
endpackage

// File: rtl/decade_digit.sv
// decade_digit: one 4-bit BCD digit with clear, load and wrapping increment
module decade_digit
  import decade_pkg::*;
(
  input  logic               c,
  input  logic               r,
  input  logic               en,
  input  logic               clr,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] q,
  output logic               tc
);
  logic [DIGIT_W-1:0] q_q, q_d;
  assign tc = q_q == BCD_MAX;
  assign q  = q_q;
  // clear beats load beats increment; a digit at 9 wraps to 0
  always_comb q_d = clr ? '0 : ld ? ld_val : en ? (tc ? '0 : q_q + 4'd1) : q_q;
  // digit register
  always_ff @(posedge c or posedge r)
    if (r) q_q <= '0;
    else   q_q <= q_d;
endmodule

// File: rtl/decade_chain_ctrl.sv
// decade_chain_ctrl: start/stop/clear/load sequencer for a chain of BCD digits
module decade_chain_ctrl
  import decade_pkg::*;
#(
  parameter int NDIG        = 3,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                    c,
  input  logic                    r,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    load,
  input  logic [DIGIT_W*NDIG-1:0] load_val,
  input  logic [DIGIT_W*NDIG-1:0] target,
  output logic [DIGIT_W*NDIG-1:0] count,
  output logic [1:0]              state,
  output logic                    running,
  output logic                    done,
  output logic                    carry_out
);
  localparam int W = DIGIT_W * NDIG;
  state_e         state_q, state_d;
  logic [W-1:0]   rel_q, rel_d, san, ld_vec;
  logic           done_q, done_d, carry_q, carry_d, inc, ld_any, match;
  logic [NDIG-1:0] tc, en;
  // count only holds BCD digits, so a non-BCD target can never compare equal
  assign match     = count == target;
  assign state     = state_q;
  assign running   = state_q == RUN;
  assign done      = done_q;
  assign carry_out = carry_q;
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    assign san[DIGIT_W*i +: DIGIT_W] = bcd_sanitise(load_val[DIGIT_W*i +: DIGIT_W]);
    if (i == 0) begin : g_first
      assign en[i] = inc;
    end else begin : g_rest
      assign en[i] = en[i-1] & tc[i-1];
    end
    decade_digit u_digit (
      .c      (c),
      .r      (r),
      .en     (en[i]),
      .clr    (clear),
      .ld     (ld_any),
      .ld_val (ld_vec[DIGIT_W*i +: DIGIT_W]),
      .q      (count[DIGIT_W*i +: DIGIT_W]),
      .tc     (tc[i])
    );
  end
  // control priority: clear > load > match/increment > stop > start
  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    done_d  = 1'b0;
    carry_d = 1'b0;
    inc     = 1'b0;
    ld_any  = 1'b0;
    ld_vec  = san;
    if (clear) begin
      state_d = IDLE;
    end else if (load) begin
      ld_any = 1'b1;
      rel_d  = san;
      if (state_q == DONE) state_d = IDLE;
    end else if (state_q == RUN) begin
      if (match) begin
        done_d = 1'b1;
        if (AUTO_RELOAD) begin
          ld_any = 1'b1;
          ld_vec = rel_q;
        end else begin
          state_d = DONE;
        end
      end else begin
        inc     = 1'b1;
        carry_d = &tc;
        if (stop) state_d = HOLD;
      end
    end else if (start) begin
      state_d = RUN;
      if (state_q == DONE) begin
        ld_any = 1'b1;
        ld_vec = rel_q;
      end
    end
  end
  // state, reload register and registered pulses
  always_ff @(posedge c or posedge r)
    if (r) begin
      state_q <= IDLE;
      rel_q   <= '0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
      carry_q <= carry_d;
    end
endmodule

// File: tb/tb_decade_chain_ctrl.sv
// tb_decade_chain_ctrl: table, directed and random checks of the decade chain sequencer
module tb_decade_chain_ctrl;
  logic        c = 1'b0, r = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic [11:0] load_val = '0, target = '0;
  logic [11:0] count0, count1;
  logic [1:0]  state0, state1;
  logic        run0, run1, done0, done1, car0, car1;
  int vectors = 0, miscompares = 0;
  int m_st[2], m_cnt[2], m_rel[2];
  bit m_done[2], m_car[2];

  always #5 c = ~c;

  decade_chain_ctrl #(.NDIG(3), .AUTO_RELOAD(1'b0)) dut0 (
    .c(c), .r(r), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_val(load_val), .target(target), .count(count0), .state(state0),
    .running(run0), .done(done0), .carry_out(car0));

  decade_chain_ctrl #(.NDIG(3), .AUTO_RELOAD(1'b1)) dut1 (
    .c(c), .r(r), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_val(load_val), .target(target), .count(count1), .state(state1),
    .running(run1), .done(done1), .carry_out(car1));

  typedef struct {
    bit cl, ld, st, sp;
    logic [11:0] lv, tg, ec;
    int es;
    bit ed, eca;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit cl, bit ld, bit st, bit sp, logic [11:0] lv, logic [11:0] tg,
                              logic [11:0] ec, int es, bit ed, bit eca);
    vec_t v;
    v.cl = cl; v.ld = ld; v.st = st; v.sp = sp; v.lv = lv; v.tg = tg;
    v.ec = ec; v.es = es; v.ed = ed; v.eca = eca;
    return v;
  endfunction

  function automatic int san_int(logic [11:0] v);
    int s, m, d;
    s = 0; m = 1;
    for (int i = 0; i < 3; i++) begin
      d = int'(v[4*i +: 4]);
      s += ((d > 9) ? 0 : d) * m;
      m *= 10;
    end
    return s;
  endfunction

  function automatic bit bcd_ok(logic [11:0] v);
    return v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && v[11:8] <= 4'd9;
  endfunction

  function automatic logic [11:0] to_bcd(int n);
    return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic cmp(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_rel[k] = 0; m_done[k] = 0; m_car[k] = 0;
    end
  endtask

  // behavioural reference: count kept as a decimal integer 0..999
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0; m_car[k] = 0;
      if (clear) begin
        m_cnt[k] = 0; m_st[k] = 0;
      end else if (load) begin
        m_cnt[k] = san_int(load_val); m_rel[k] = m_cnt[k];
        if (m_st[k] == 3) m_st[k] = 0;
      end else if (m_st[k] == 1) begin
        if (bcd_ok(target) && m_cnt[k] == san_int(target)) begin
          m_done[k] = 1;
          if (k == 1) m_cnt[k] = m_rel[k];
          else m_st[k] = 3;
        end else begin
          m_car[k] = m_cnt[k] == 999;
          m_cnt[k] = (m_cnt[k] + 1) % 1000;
          if (stop) m_st[k] = 2;
        end
      end else if (start) begin
        if (m_st[k] == 3) m_cnt[k] = m_rel[k];
        m_st[k] = 1;
      end
    end
  endtask

  task automatic chk_dut(int k, logic [11:0] cn, logic [1:0] s, logic ru, logic d, logic ca);
    cmp($sformatf("dut%0d_count", k), cn, to_bcd(m_cnt[k]));
    cmp($sformatf("dut%0d_state", k), s, m_st[k]);
    cmp($sformatf("dut%0d_running", k), ru, m_st[k] == 1);
    cmp($sformatf("dut%0d_done", k), d, m_done[k]);
    cmp($sformatf("dut%0d_carry", k), ca, m_car[k]);
  endtask

  task automatic chk_model();
    chk_dut(0, count0, state0, run0, done0, car0);
    chk_dut(1, count1, state1, run1, done1, car1);
  endtask

  task automatic step(bit cl, bit ld, bit st, bit sp, logic [11:0] lv, logic [11:0] tg);
    clear = cl; load = ld; start = st; stop = sp; load_val = lv; target = tg;
    @(posedge c);
    model_edge();
    #1;
    chk_model();
  endtask

  logic [11:0] lvr, tgr;

  initial begin
    tbl.push_back(mk(0,1,0,0,12'h007,12'h012,12'h007,0,0,0));
    tbl.push_back(mk(0,0,1,0,12'h007,12'h012,12'h007,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h007,12'h012,12'h008,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h007,12'h012,12'h009,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h007,12'h012,12'h010,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h007,12'h012,12'h011,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h007,12'h012,12'h012,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h007,12'h012,12'h012,3,1,0));
    tbl.push_back(mk(0,0,0,0,12'h007,12'h012,12'h012,3,0,0));
    tbl.push_back(mk(0,0,0,1,12'h007,12'h012,12'h012,3,0,0));
    tbl.push_back(mk(0,0,1,0,12'h007,12'h012,12'h007,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h007,12'h012,12'h008,1,0,0));
    tbl.push_back(mk(1,0,0,0,12'h007,12'h012,12'h000,0,0,0));
    tbl.push_back(mk(0,1,0,0,12'h998,12'h050,12'h998,0,0,0));
    tbl.push_back(mk(0,0,1,0,12'h998,12'h050,12'h998,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h998,12'h050,12'h999,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h998,12'h050,12'h000,1,0,1));
    tbl.push_back(mk(0,0,0,0,12'h998,12'h050,12'h001,1,0,0));
    tbl.push_back(mk(1,0,0,0,12'h998,12'h050,12'h000,0,0,0));
    tbl.push_back(mk(0,1,0,0,12'h032,12'h050,12'h032,0,0,0));
    tbl.push_back(mk(0,0,1,0,12'h032,12'h050,12'h032,1,0,0));
    tbl.push_back(mk(0,0,0,1,12'h032,12'h050,12'h033,2,0,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,0,12'h032,12'h050,12'h033,2,0,0));
    tbl.push_back(mk(0,0,0,1,12'h032,12'h050,12'h033,2,0,0));
    tbl.push_back(mk(0,0,1,0,12'h032,12'h050,12'h033,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h032,12'h050,12'h034,1,0,0));
    tbl.push_back(mk(0,0,1,1,12'h032,12'h050,12'h035,2,0,0));
    tbl.push_back(mk(0,0,1,1,12'h032,12'h050,12'h035,1,0,0));
    tbl.push_back(mk(0,0,1,0,12'h032,12'h050,12'h036,1,0,0));
    tbl.push_back(mk(0,1,0,0,12'h01A,12'h050,12'h010,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h01A,12'h050,12'h011,1,0,0));
    tbl.push_back(mk(1,1,0,0,12'h055,12'h050,12'h000,0,0,0));
    tbl.push_back(mk(0,0,1,0,12'h055,12'h00F,12'h000,1,0,0));
    tbl.push_back(mk(0,1,0,0,12'h997,12'h00F,12'h997,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h997,12'h00F,12'h998,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h997,12'h00F,12'h999,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h997,12'h00F,12'h000,1,0,1));
    tbl.push_back(mk(0,0,0,0,12'h997,12'h00F,12'h001,1,0,0));
    tbl.push_back(mk(1,0,0,0,12'h997,12'h00F,12'h000,0,0,0));
    tbl.push_back(mk(0,0,0,1,12'h997,12'h00F,12'h000,0,0,0));
    tbl.push_back(mk(0,1,0,0,12'h005,12'h007,12'h005,0,0,0));
    tbl.push_back(mk(0,0,1,0,12'h005,12'h007,12'h005,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h005,12'h007,12'h006,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h005,12'h007,12'h007,1,0,0));
    tbl.push_back(mk(0,0,0,0,12'h005,12'h007,12'h007,3,1,0));
    tbl.push_back(mk(0,1,0,0,12'h003,12'h007,12'h003,0,0,0));

    model_reset();
    #12;
    cmp("reset_count", count0, 12'h000);
    cmp("reset_state", state0, 0);
    chk_model();
    r = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].cl, tbl[i].ld, tbl[i].st, tbl[i].sp, tbl[i].lv, tbl[i].tg);
      cmp($sformatf("row%0d_count", i), count0, tbl[i].ec);
      cmp($sformatf("row%0d_state", i), state0, tbl[i].es);
      cmp($sformatf("row%0d_done", i), done0, tbl[i].ed);
      cmp($sformatf("row%0d_carry", i), car0, tbl[i].eca);
    end

    // asynchronous reset while counting at 456
    step(1, 0, 0, 0, 12'h000, 12'hFFF);
    step(0, 1, 0, 0, 12'h455, 12'hFFF);
    step(0, 0, 1, 0, 12'h455, 12'hFFF);
    step(0, 0, 0, 0, 12'h455, 12'hFFF);
    cmp("midrun_pre_count", count0, 12'h456);
    #2 r = 1'b1;
    #1;
    model_reset();
    cmp("midrun_rst_count", count0, 12'h000);
    cmp("midrun_rst_state", state0, 0);
    chk_model();
    #1 r = 1'b0;
    step(0, 0, 1, 0, 12'h455, 12'hFFF);
    cmp("midrun_restart_count", count0, 12'h000);
    cmp("midrun_restart_state", state0, 1);
    step(0, 0, 0, 0, 12'h455, 12'hFFF);
    cmp("midrun_first_inc", count0, 12'h001);

    // auto-reload on the second instance
    step(1, 0, 0, 0, 12'h000, 12'h007);
    step(0, 1, 0, 0, 12'h005, 12'h007);
    step(0, 0, 1, 0, 12'h005, 12'h007);
    cmp("ar_start", count1, 12'h005);
    step(0, 0, 0, 0, 12'h005, 12'h007);
    cmp("ar_06", count1, 12'h006);
    step(0, 0, 0, 0, 12'h005, 12'h007);
    cmp("ar_07", count1, 12'h007);
    step(0, 0, 0, 0, 12'h005, 12'h007);
    cmp("ar_reload_count", count1, 12'h005);
    cmp("ar_reload_done", done1, 1);
    cmp("ar_reload_state", state1, 1);
    step(0, 0, 0, 0, 12'h005, 12'h007);
    cmp("ar_after_count", count1, 12'h006);
    cmp("ar_after_done", done1, 0);

    // randomized traffic against the reference model
    lvr = '0; tgr = '0;
    for (int n = 0; n < 800; n++) begin
      if (n % 40 == 0) begin
        lvr = to_bcd(($urandom_range(0, 3) == 0) ? int'($urandom_range(985, 999)) : int'($urandom_range(0, 999)));
        tgr = to_bcd((san_int(lvr) + int'($urandom_range(0, 20))) % 1000);
        if ($urandom_range(0, 7) == 0) tgr[3:0] = 4'hC;
        if ($urandom_range(0, 7) == 0) lvr[7:4] = 4'($urandom_range(0, 15));
      end
      step($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, lvr, tgr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
